ip_tile_fsm_param_shifter: RTL and testbench
============================================

Name: ip_tile_fsm_param_shifter

Overview:
- Parametrised successor of the IP-tile FSM bitwise shifter. It sits behind the same tile CSR/data-register interface.
- Shifts operand A or B by up to REG_WIDTH bits, STEP bits per cycle, in logical, arithmetic or rotate mode. Result goes to data_reg_c.
- Reports done, busy, error and carry-out in csr_out, with a one-cycle write strobe.

Parameters:
- REG_WIDTH, 32, operand/result width; allowed 8..64.
- CSR_IN_WIDTH, 16, csr_in width; must be >=16.
- CSR_OUT_WIDTH, 16, csr_out width; must be >=16.
- STEP, 1, bits shifted per SHIFT cycle; must be a power of 2 and <=REG_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- csr_in  in  CSR_IN_WIDTH  command word
- csr_in_re  in  1  csr_in valid strobe
- data_reg_a  in  REG_WIDTH  operand A
- data_reg_b  in  REG_WIDTH  operand B
- csr_out  out  CSR_OUT_WIDTH  status word
- csr_out_we  out  1  status write strobe
- data_reg_c  out  REG_WIDTH  result

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. On any cycle with rst=1: state=IDLE; data_reg_c=0; csr_out=0; csr_out_we=0; internal operand, counter and carry registers cleared.
- csr_in fields:
  - [0] sel_a, [1] sel_b
  - [2] right, [3] left
  - [10:4] amt, 0..127; amt>REG_WIDTH saturates to REG_WIDTH
  - [12:11] mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved
  - [14:13] ignored
  - [15] start
- Command accept: a command is accepted only when csr_in_re=1, csr_in[15]=1 and state=IDLE.
- Config error: exactly one of sel_a/sel_b must be set, exactly one of right/left, and mode must not be 11. On violation: stay in IDLE; set err_cfg; clear done; pulse csr_out_we; data_reg_c unchanged.
- Start while busy: csr_in_re with start=1 in any state other than IDLE is ignored and sets sticky err_busy (csr_out_we pulse). The operation in flight is unaffected.
- FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - IDLE: on an accepted command, latch sel/dir/mode/amt; clear done, err_cfg, err_busy and carry; set busy; pulse csr_out_we.
  - LOAD (1 cycle): capture the selected operand into the working register. Go to DONE if amt==0, else SHIFT with remaining=amt.
  - SHIFT: each cycle shift by min(STEP, remaining). Track carry = last bit shifted out (rotate: last bit wrapped). Go to DONE when remaining reaches 0.
  - DONE (1 cycle): data_reg_c <= working register; set done; clear busy; pulse csr_out_we; go to IDLE.
- Latency from accept cycle N: data_reg_c valid at N+2+ceil(amt/STEP).
- Arithmetic rules:
  - Logical: zero fill; amt=REG_WIDTH gives 0.
  - Arithmetic right: sign fill, so amt>=REG_WIDTH gives all sign bits.
  - Arithmetic left is identical to logical left.
  - Rotate: amt=REG_WIDTH gives the operand unchanged.
- Operand source: A/B are sampled only in LOAD; later changes to data_reg_a/b do not affect the running operation.
- csr_out bits:
  - [0] done, [1] busy, [2] err_cfg, [3] err_busy, [4] carry.
  - [7:5] are 0; [15:8] are 0 unless the optional feature is enabled.
  - All bits hold their value between csr_out_we pulses.
- Reset mid-operation: the operation is abandoned and no DONE is produced. The next command after rst deasserts behaves normally.

Optional Feature:
- Macro: SHIFTER_CYCLE_CNT_EN.
- Defined: an 8-bit counter counts cycles from accept to DONE inclusive, saturating at 255. It is written to csr_out[15:8] at DONE and cleared on accept and on rst.
- Undefined: csr_out[15:8] is tied to 0 and no counter logic is present.

Decomposition:
- Package ip_tile_shifter_pkg holds:
  - state enum: IDLE, LOAD, SHIFT, DONE
  - mode enum: LOGIC, ARITH, ROT, RSVD
  - csr_in field position constants: START_BIT, SEL_A_BIT, SEL_B_BIT, DIR_R_BIT, DIR_L_BIT, AMT_LSB, AMT_MSB, MODE_LSB
  - csr_out status bit constants: DONE_BIT, BUSY_BIT, ERR_CFG_BIT, ERR_BUSY_BIT, CARRY_BIT, CNT_LSB
- Sub-module shifter_step_unit: combinational; takes word, dir, mode and count (0..STEP) and returns the shifted word and carry. The FSM top instantiates it once.

Test Plan (REG_WIDTH=32, STEP=1 unless noted):
- Logical right, A=0xA5A5A5A5, amt=32 -> c=0x00000000, carry=1, done at accept+34 cycles, busy is 1 throughout the shift.
- Arithmetic right, B=0xF0000000, amt=4 -> c=0xFF000000, carry=0. Repeat with STEP=4 -> same result, latency accept+3.
- Rotate left, A=0x12345678, amt=8 -> c=0x34567812. Rotate right, amt=32 -> c=0x12345678.
- Second start issued 8 cycles into A=0x12345678 logical left by 32 -> second command ignored, err_busy=1, c=0x00000000. Then csr_in=0x8003 (both sels) -> err_cfg=1, no busy, c unchanged.
- Edge amounts: amt=0 on A=0xAAAAAAAA -> c=0xAAAAAAAA at accept+2. amt=40 logical left on 0xFFFFFFFF -> saturates to 32 -> c=0.
- rst=1 for one cycle during the 4th SHIFT cycle of A=0xCAFEBABE left by 32 -> csr_out=0, c=0, no done pulse. A following amt=4 left shift -> c=0xAFEBABE0.

Source files
------------

// File: rtl/ip_tile_shifter_pkg.sv
// Shared types and csr field positions for the parametrised IP-tile shifter.
package ip_tile_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        LOGIC = 2'd0,
        ARITH = 2'd1,
        ROT   = 2'd2,
        RSVD  = 2'd3
    } mode_e;

    // csr_in command fields
    localparam int unsigned SEL_A_BIT = 0;
    localparam int unsigned SEL_B_BIT = 1;
    localparam int unsigned DIR_R_BIT = 2;
    localparam int unsigned DIR_L_BIT = 3;
    localparam int unsigned AMT_LSB   = 4;
    localparam int unsigned AMT_MSB   = 10;
    localparam int unsigned MODE_LSB  = 11;
    localparam int unsigned START_BIT = 15;

    // csr_out status fields
    localparam int unsigned DONE_BIT     = 0;
    localparam int unsigned BUSY_BIT     = 1;
    localparam int unsigned ERR_CFG_BIT  = 2;
    localparam int unsigned ERR_BUSY_BIT = 3;
    localparam int unsigned CARRY_BIT    = 4;
    localparam int unsigned CNT_LSB      = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/shifter_step_unit.sv
// Combinational shift of one word by 0..STEP bits; carry is the last bit moved out
// (or wrapped, in rotate mode).
module shifter_step_unit
    import ip_tile_shifter_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned STEP      = 1
) (
    input  logic [REG_WIDTH-1:0]           word,
    input  logic                           left,
    input  mode_e                          mode,
    input  logic [$clog2(STEP + 1)-1:0]    count,
    output logic [REG_WIDTH-1:0]           shifted_c,
    output logic                           carry_c
);
    localparam int unsigned CNT_W = $clog2(STEP + 1);

    // Unrolled single-bit stages, each enabled while its index is below count.
    always_comb begin
        shifted_c = word;
        carry_c   = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (CNT_W'(i) < count) begin
                if (left) begin
                    carry_c   = shifted_c[REG_WIDTH-1];
                    shifted_c = {shifted_c[REG_WIDTH-2:0],
                                 (mode == ROT) ? shifted_c[REG_WIDTH-1] : 1'b0};
                end else begin
                    carry_c   = shifted_c[0];
                    shifted_c = {(mode == ROT)   ? shifted_c[0] :
                                 (mode == ARITH) ? shifted_c[REG_WIDTH-1] : 1'b0,
                                 shifted_c[REG_WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/ip_tile_fsm_param_shifter.sv
// CSR-driven tile shifter: shifts operand A or B by up to REG_WIDTH bits, STEP bits per cycle.
// Optional macro SHIFTER_CYCLE_CNT_EN reports accept-to-DONE cycle count in csr_out[15:8].
module ip_tile_fsm_param_shifter
    import ip_tile_shifter_pkg::*;
#(
    parameter int unsigned REG_WIDTH     = 32,
    parameter int unsigned CSR_IN_WIDTH  = 16,
    parameter int unsigned CSR_OUT_WIDTH = 16,
    parameter int unsigned STEP          = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic                     csr_in_re,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_out_we,
    output logic [REG_WIDTH-1:0]     data_reg_c
);
    localparam int unsigned AMT_W = AMT_MSB - AMT_LSB + 1;
    localparam int unsigned CNT_W = $clog2(STEP + 1);

    state_e               state;
    mode_e                mode;
    logic                 use_b;
    logic                 left;
    logic [AMT_W-1:0]     amt;
    logic [AMT_W-1:0]     remaining;
    logic [REG_WIDTH-1:0] work;
    logic                 shift_carry;
    logic                 done;
    logic                 busy;
    logic                 err_cfg;
    logic                 err_busy;
    logic                 carry;
`ifdef SHIFTER_CYCLE_CNT_EN
    logic [7:0]           cyc_cnt;
    logic [7:0]           cyc_out;
`endif

    logic                 start_req;
    logic                 cfg_ok;
    mode_e                cmd_mode;
    logic [AMT_W-1:0]     amt_raw;
    logic [AMT_W-1:0]     amt_sat;
    logic [CNT_W-1:0]     step_cnt;
    logic [REG_WIDTH-1:0] step_word;
    logic                 step_carry;
    logic                 unused_bits;

    // Command decode; reserved csr_in bits are intentionally ignored.
    assign start_req   = csr_in_re & csr_in[START_BIT];
    assign cmd_mode    = mode_e'(csr_in[MODE_LSB +: 2]);
    assign cfg_ok      = (csr_in[SEL_A_BIT] ^ csr_in[SEL_B_BIT]) &
                         (csr_in[DIR_R_BIT] ^ csr_in[DIR_L_BIT]) &
                         (cmd_mode != RSVD);
    assign amt_raw     = csr_in[AMT_MSB:AMT_LSB];
    assign amt_sat     = (amt_raw > AMT_W'(REG_WIDTH)) ? AMT_W'(REG_WIDTH) : amt_raw;
    assign step_cnt    = (remaining >= AMT_W'(STEP)) ? CNT_W'(STEP) : CNT_W'(remaining);
    assign unused_bits = ^csr_in;

    shifter_step_unit #(
        .REG_WIDTH (REG_WIDTH),
        .STEP      (STEP)
    ) u_step (
        .word      (work),
        .left      (left),
        .mode      (mode),
        .count     (step_cnt),
        .shifted_c (step_word),
        .carry_c   (step_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode        <= LOGIC;
            use_b       <= 1'b0;
            left        <= 1'b0;
            amt         <= '0;
            remaining   <= '0;
            work        <= '0;
            shift_carry <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            err_cfg     <= 1'b0;
            err_busy    <= 1'b0;
            carry       <= 1'b0;
            data_reg_c  <= '0;
            csr_out_we  <= 1'b0;
`ifdef SHIFTER_CYCLE_CNT_EN
            cyc_cnt     <= '0;
            cyc_out     <= '0;
`endif
        end else begin
            csr_out_we <= 1'b0;
            // A start outside IDLE only flags; the running operation is untouched.
            if (start_req && state != IDLE) begin
                err_busy   <= 1'b1;
                csr_out_we <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start_req) begin
                        csr_out_we <= 1'b1;
                        if (cfg_ok) begin
                            use_b       <= csr_in[SEL_B_BIT];
                            left        <= csr_in[DIR_L_BIT];
                            mode        <= cmd_mode;
                            amt         <= amt_sat;
                            done        <= 1'b0;
                            err_cfg     <= 1'b0;
                            err_busy    <= 1'b0;
                            carry       <= 1'b0;
                            shift_carry <= 1'b0;
                            busy        <= 1'b1;
                            state       <= LOAD;
`ifdef SHIFTER_CYCLE_CNT_EN
                            cyc_cnt     <= 8'd1;
                            cyc_out     <= '0;
`endif
                        end else begin
                            err_cfg <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    work      <= use_b ? data_reg_b : data_reg_a;
                    remaining <= amt;
                    state     <= (amt == '0) ? DONE : SHIFT;
`ifdef SHIFTER_CYCLE_CNT_EN
                    cyc_cnt   <= sat_inc8(cyc_cnt);
`endif
                end
                SHIFT: begin
                    work        <= step_word;
                    shift_carry <= step_carry;
                    remaining   <= remaining - AMT_W'(step_cnt);
                    if (remaining <= AMT_W'(STEP)) begin
                        state <= DONE;
                    end
`ifdef SHIFTER_CYCLE_CNT_EN
                    cyc_cnt     <= sat_inc8(cyc_cnt);
`endif
                end
                DONE: begin
                    data_reg_c <= work;
                    carry      <= shift_carry;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    csr_out_we <= 1'b1;
                    state      <= IDLE;
`ifdef SHIFTER_CYCLE_CNT_EN
                    cyc_out    <= sat_inc8(cyc_cnt);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status word is pure wiring of flops that only change alongside a csr_out_we pulse.
    always_comb begin
        csr_out               = '0;
        csr_out[DONE_BIT]     = done;
        csr_out[BUSY_BIT]     = busy;
        csr_out[ERR_CFG_BIT]  = err_cfg;
        csr_out[ERR_BUSY_BIT] = err_busy;
        csr_out[CARRY_BIT]    = carry;
`ifdef SHIFTER_CYCLE_CNT_EN
        csr_out[CNT_LSB +: 8] = cyc_out;
`endif
    end

endmodule

// File: tb/tb_ip_tile_fsm_param_shifter.sv
// Self-checking bench for ip_tile_fsm_param_shifter: STEP=1 and STEP=4 instances against
// an arithmetic reference model, directed scenarios plus randomized commands.
module tb_ip_tile_fsm_param_shifter;
    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   csr_in;
    logic          re1;
    logic          re4;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [15:0]   out1;
    logic [15:0]   out4;
    logic          we1;
    logic          we4;
    logic [W-1:0]  c1;
    logic [W-1:0]  c4;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_c1;
    logic [W-1:0] exp_c4;

    always #5 clk = ~clk;

    ip_tile_fsm_param_shifter #(.REG_WIDTH(W), .CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .csr_in(csr_in), .csr_in_re(re1),
        .data_reg_a(a), .data_reg_b(b),
        .csr_out(out1), .csr_out_we(we1), .data_reg_c(c1)
    );

    ip_tile_fsm_param_shifter #(.REG_WIDTH(W), .CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .csr_in(csr_in), .csr_in_re(re4),
        .data_reg_a(a), .data_reg_b(b),
        .csr_out(out4), .csr_out_we(we4), .data_reg_c(c4)
    );

    // Reference: result and carry from whole-word arithmetic on the saturated amount.
    function automatic logic [W:0] model(input logic [W-1:0] op, input bit left,
                                         input logic [1:0] mode, input int amt_raw);
        int amt;
        logic [2*W-1:0] t;
        logic [W-1:0] r;
        logic cy;
        amt = (amt_raw > int'(W)) ? int'(W) : amt_raw;
        if (amt == 0) begin
            r  = op;
            cy = 1'b0;
        end else if (mode == 2'd2) begin
            if (left) begin
                t  = {op, op} << amt;
                r  = t[2*W-1:W];
                cy = r[0];
            end else begin
                t  = {op, op} >> amt;
                r  = t[W-1:0];
                cy = r[W-1];
            end
        end else if (left) begin
            t  = {{W{1'b0}}, op} << amt;
            r  = t[W-1:0];
            cy = t[W];
        end else begin
            t  = {(mode == 2'd1) ? {W{op[W-1]}} : {W{1'b0}}, op};
            r  = t[amt +: W];
            cy = t[amt-1];
        end
        return {cy, r};
    endfunction

    function automatic logic [15:0] mk(input bit use_b, input bit left,
                                       input logic [1:0] mode, input int amt);
        logic [15:0] v;
        v        = 16'h8000;
        v[0]     = !use_b;
        v[1]     = use_b;
        v[2]     = !left;
        v[3]     = left;
        v[10:4]  = 7'(amt);
        v[12:11] = mode;
        return v;
    endfunction

    // Present a command for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [15:0] cmd, input bit to1, input bit to4);
        @(negedge clk);
        csr_in = cmd;
        re1    = to1;
        re4    = to4;
        @(negedge clk);
        csr_in = '0;
        re1    = 1'b0;
        re4    = 1'b0;
    endtask

    // Bounded wait for DONE pulses; latency -1 means the bound expired.
    task automatic wait_both(input bit want1, input bit want4, input bit scramble,
                             output int l1, output int l4);
        bit g1;
        bit g4;
        g1 = !want1;
        g4 = !want4;
        l1 = -1;
        l4 = -1;
        for (int i = 1; i <= 200 && !(g1 && g4); i++) begin
            @(negedge clk);
            if (scramble && i == 1) begin
                a = $urandom;
                b = $urandom;
            end
            if (!g1 && we1 && out1[0]) begin g1 = 1'b1; l1 = i; end
            if (!g4 && we4 && out4[0]) begin g4 = 1'b1; l4 = i; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out1 !== 16'h0) begin errors++; $display("FAIL reset_csr1: got %h expected 0000", out1); end
        checks++; if (c1 !== '0) begin errors++; $display("FAIL reset_c1: got %h expected 00000000", c1); end
        checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL reset_we1: got %b expected 0", we1); end
        checks++; if (out4 !== 16'h0 || c4 !== '0) begin errors++; $display("FAIL reset_dut4: csr %h c %h expected 0", out4, c4); end
        rst = 1'b0;
        exp_c1 = '0;
        exp_c4 = '0;
    endtask

    task automatic test_logical_right();
        int lat;
        int busy_bad;
        bit seen;
        lat = -1; busy_bad = 0; seen = 1'b0;
        a = 32'hA5A5A5A5;
        issue(mk(0, 0, 2'd0, 32), 1, 0);
        checks++; if (we1 !== 1'b1 || out1[1] !== 1'b1 || out1[0] !== 1'b0) begin
            errors++; $display("FAIL lsr_accept: we %b csr %h expected we 1 busy 1 done 0", we1, out1); end
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (we1 && out1[0]) begin seen = 1'b1; lat = i; end
            else if (out1[1] !== 1'b1) busy_bad++;
        end
        checks++; if (lat != 34) begin errors++; $display("FAIL lsr_latency: got %0d expected 34", lat); end
        checks++; if (c1 !== 32'h0) begin errors++; $display("FAIL lsr_result: got %h expected 00000000", c1); end
        checks++; if (out1[4] !== 1'b1) begin errors++; $display("FAIL lsr_carry: got %b expected 1", out1[4]); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL lsr_busy_hold: %0d cycles without busy, expected 0", busy_bad); end
        checks++; if (out1[1] !== 1'b0) begin errors++; $display("FAIL lsr_busy_clear: got %b expected 0", out1[1]); end
        exp_c1 = 32'h0;
    endtask

    task automatic test_arith_right();
        int l1;
        int l4;
        b = 32'hF0000000;
        issue(mk(1, 0, 2'd1, 4), 1, 1);
        wait_both(1, 1, 0, l1, l4);
        checks++; if (c1 !== 32'hFF000000) begin errors++; $display("FAIL asr_result1: got %h expected ff000000", c1); end
        checks++; if (out1[4] !== 1'b0) begin errors++; $display("FAIL asr_carry1: got %b expected 0", out1[4]); end
        checks++; if (l1 != 6) begin errors++; $display("FAIL asr_latency1: got %0d expected 6", l1); end
        checks++; if (c4 !== 32'hFF000000) begin errors++; $display("FAIL asr_result4: got %h expected ff000000", c4); end
        checks++; if (l4 != 3) begin errors++; $display("FAIL asr_latency4: got %0d expected 3", l4); end
        exp_c1 = 32'hFF000000;
        exp_c4 = 32'hFF000000;
    endtask

    task automatic test_rotate();
        int l1;
        int l4;
        a = 32'h12345678;
        issue(mk(0, 1, 2'd2, 8), 1, 1);
        wait_both(1, 1, 0, l1, l4);
        checks++; if (c1 !== 32'h34567812 || l1 != 10) begin errors++; $display("FAIL rol8_dut1: got %h lat %0d expected 34567812 lat 10", c1, l1); end
        checks++; if (c4 !== 32'h34567812 || l4 != 4) begin errors++; $display("FAIL rol8_dut4: got %h lat %0d expected 34567812 lat 4", c4, l4); end
        issue(mk(0, 0, 2'd2, 32), 1, 1);
        wait_both(1, 1, 0, l1, l4);
        checks++; if (c1 !== 32'h12345678 || l1 != 34) begin errors++; $display("FAIL ror32_dut1: got %h lat %0d expected 12345678 lat 34", c1, l1); end
        checks++; if (c4 !== 32'h12345678 || l4 != 10) begin errors++; $display("FAIL ror32_dut4: got %h lat %0d expected 12345678 lat 10", c4, l4); end
        exp_c1 = 32'h12345678;
        exp_c4 = 32'h12345678;
    endtask

    task automatic test_busy_error();
        int l1;
        int l4;
        a = 32'h12345678;
        issue(mk(0, 1, 2'd0, 32), 1, 0);
        repeat (7) @(negedge clk);
        issue(mk(1, 0, 2'd2, 3), 1, 0);
        checks++; if (we1 !== 1'b1 || out1[3] !== 1'b1 || out1[1] !== 1'b1) begin
            errors++; $display("FAIL busy_err_flag: we %b csr %h expected we 1 err_busy 1 busy 1", we1, out1); end
        wait_both(1, 0, 0, l1, l4);
        checks++; if (l1 != 25) begin errors++; $display("FAIL busy_err_latency: got %0d expected 25", l1); end
        checks++; if (c1 !== 32'h0) begin errors++; $display("FAIL busy_err_result: got %h expected 00000000", c1); end
        checks++; if (out1[3] !== 1'b1) begin errors++; $display("FAIL busy_err_sticky: got %b expected 1", out1[3]); end
        exp_c1 = 32'h0;
        issue(16'h8003, 1, 0);
        checks++; if (we1 !== 1'b1 || out1[2] !== 1'b1 || out1[1] !== 1'b0 || out1[0] !== 1'b0) begin
            errors++; $display("FAIL cfg_err_flags: we %b csr %h expected we 1 err_cfg 1 busy 0 done 0", we1, out1); end
        repeat (3) @(negedge clk);
        checks++; if (c1 !== exp_c1 || out1[1] !== 1'b0) begin errors++; $display("FAIL cfg_err_idle: c %h busy %b expected c %h busy 0", c1, out1[1], exp_c1); end
    endtask

    task automatic test_edge_amounts();
        int l1;
        int l4;
        a = 32'hAAAAAAAA;
        issue(mk(0, 0, 2'd0, 0), 1, 1);
        wait_both(1, 1, 0, l1, l4);
        checks++; if (c1 !== 32'hAAAAAAAA || l1 != 2) begin errors++; $display("FAIL amt0_dut1: got %h lat %0d expected aaaaaaaa lat 2", c1, l1); end
        checks++; if (c4 !== 32'hAAAAAAAA || l4 != 2) begin errors++; $display("FAIL amt0_dut4: got %h lat %0d expected aaaaaaaa lat 2", c4, l4); end
        a = 32'hFFFFFFFF;
        issue(mk(0, 1, 2'd0, 40), 1, 1);
        wait_both(1, 1, 0, l1, l4);
        checks++; if (c1 !== 32'h0 || l1 != 34 || out1[4] !== 1'b1) begin
            errors++; $display("FAIL amt40_dut1: got %h lat %0d carry %b expected 00000000 lat 34 carry 1", c1, l1, out1[4]); end
        checks++; if (c4 !== 32'h0 || l4 != 10) begin errors++; $display("FAIL amt40_dut4: got %h lat %0d expected 00000000 lat 10", c4, l4); end
        exp_c1 = 32'h0;
        exp_c4 = 32'h0;
    endtask

    task automatic test_reset_mid();
        int l1;
        int l4;
        int pulses;
        pulses = 0;
        a = 32'hCAFEBABE;
        issue(mk(0, 1, 2'd0, 32), 1, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out1 !== 16'h0 || c1 !== '0 || we1 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state: csr %h c %h we %b expected all 0", out1, c1, we1); end
        repeat (50) begin
            @(negedge clk);
            if (we1 && out1[0]) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", pulses); end
        exp_c1 = '0;
        exp_c4 = '0;
        issue(mk(0, 1, 2'd0, 4), 1, 0);
        wait_both(1, 0, 0, l1, l4);
        checks++; if (c1 !== 32'hAFEBABE0 || l1 != 6) begin errors++; $display("FAIL rst_mid_next: got %h lat %0d expected afebabe0 lat 6", c1, l1); end
        exp_c1 = 32'hAFEBABE0;
    endtask

    task automatic test_random();
        int l1;
        int l4;
        int amt;
        int sat;
        bit use_b;
        bit left;
        logic [1:0] mode;
        logic [15:0] cmd;
        logic [W-1:0] op;
        logic [W:0] m;
        for (int n = 0; n < 40; n++) begin
            a     = $urandom;
            b     = $urandom;
            use_b = 1'($urandom_range(0, 1));
            left  = 1'($urandom_range(0, 1));
            mode  = 2'($urandom_range(0, 2));
            amt   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 34));
            cmd   = mk(use_b, left, mode, amt);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: cmd[1:0]   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                    1: cmd[3:2]   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                    default: cmd[12:11] = 2'b11;
                endcase
                issue(cmd, 1, 1);
                checks++; if (we1 !== 1'b1 || out1[2] !== 1'b1 || out1[1] !== 1'b0 || c1 !== exp_c1) begin
                    errors++; $display("FAIL rnd_cfg1 #%0d: cmd %h csr %h c %h expected err_cfg 1 c %h", n, cmd, out1, c1, exp_c1); end
                checks++; if (we4 !== 1'b1 || out4[2] !== 1'b1 || out4[1] !== 1'b0 || c4 !== exp_c4) begin
                    errors++; $display("FAIL rnd_cfg4 #%0d: cmd %h csr %h c %h expected err_cfg 1 c %h", n, cmd, out4, c4, exp_c4); end
            end else begin
                op  = use_b ? b : a;
                m   = model(op, left, mode, amt);
                sat = (amt > int'(W)) ? int'(W) : amt;
                issue(cmd, 1, 1);
                wait_both(1, 1, 1, l1, l4);
                checks++; if (c1 !== m[W-1:0] || out1[4] !== m[W] || l1 != 2 + sat) begin
                    errors++; $display("FAIL rnd_dut1 #%0d: cmd %h op %h got %h carry %b lat %0d expected %h carry %b lat %0d",
                                       n, cmd, op, c1, out1[4], l1, m[W-1:0], m[W], 2 + sat); end
                checks++; if (c4 !== m[W-1:0] || out4[4] !== m[W] || l4 != 2 + (sat + 3) / 4) begin
                    errors++; $display("FAIL rnd_dut4 #%0d: cmd %h op %h got %h carry %b lat %0d expected %h carry %b lat %0d",
                                       n, cmd, op, c4, out4[4], l4, m[W-1:0], m[W], 2 + (sat + 3) / 4); end
                exp_c1 = m[W-1:0];
                exp_c4 = m[W-1:0];
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        csr_in = '0;
        re1    = 1'b0;
        re4    = 1'b0;
        a      = '0;
        b      = '0;
        test_reset();
        test_logical_right();
        test_arith_right();
        test_rotate();
        test_busy_error();
        test_edge_amounts();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
